// File: rtl/rr_reg_write_arbiter_if.sv
// Bus between the write agents and the shared-register arbiter.
// Requester i drives req[i], lock[i] and wdata[i]. The arbiter returns the
// grant and ack vectors, the register contents, the owner index and busy.
interface rr_reg_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            lock;
  logic [N_REQ-1:0][WIDTH-1:0] wdata;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            ack;
  logic [WIDTH-1:0]            q;
  logic [PW-1:0]               owner;
  logic                        busy;

  modport master (output req, lock, wdata, input gnt, ack, q, owner, busy);
  modport slave  (input req, lock, wdata, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter that gives one requester at a time write ownership of
// a shared WIDTH-bit register. A locked owner may write on back-to-back
// cycles, but it is released after MAX_HOLD writes so that the others get a turn.

// Per-lane grant and ack next-state logic.
module rr_reg_write_lane #(
  parameter int PW   = 2,
  parameter int LANE = 0
) (
  input  logic          take_gnt,
  input  logic          release_own,
  input  logic          wr_en,
  input  logic [PW-1:0] sel_idx,
  input  logic [PW-1:0] owner,
  input  logic          gnt_q_i,
  output logic          gnt_d_o,
  output logic          ack_d_o
);
  // Grant is set on arbitration and cleared on release. Ack pulses on a commit.
  always_comb begin
    gnt_d_o = gnt_q_i;
    if (take_gnt)         gnt_d_o = (sel_idx == PW'(LANE));
    else if (release_own) gnt_d_o = 1'b0;
    ack_d_o = wr_en && (owner == PW'(LANE));
  end
endmodule

module rr_reg_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_reg_write_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;

  logic              sel_found;
  logic [PW-1:0]     sel_idx;
  logic              wr_en;
  logic              keep;
  logic              take_gnt;
  logic              release_own;

  // Pick the first requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_v;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % N_REQ;
      idx_v = PW'(idx);
      if (!sel_found && bus.req[idx_v]) begin
        sel_found = 1'b1;
        sel_idx   = idx_v;
      end
    end
  end

  // Owner-side decisions. Requests and locks from non-owners are never looked at here.
  always_comb begin
    wr_en       = (state_q == OWNED) && bus.req[owner_q];
    keep        = wr_en && bus.lock[owner_q] && ((int'(hold_cnt_q) + 1) < MAX_HOLD);
    take_gnt    = (state_q == IDLE) && sel_found;
    release_own = (state_q == OWNED) && !keep;
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      q_q        <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      q_q        <= q_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state. A release always passes through IDLE, so a new grant comes one edge later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_gnt) state_d = OWNED;
      OWNED:   if (!keep)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register write, owner tracking, hold counter and rotation pointer.
  always_comb begin
    q_d        = q_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (take_gnt) begin
      owner_d    = sel_idx;
      hold_cnt_d = '0;
    end
    if (wr_en) begin
      q_d        = bus.wdata[owner_q];
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
    if (release_own)
      rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
  end

  // Grant and ack bits, one lane instance per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    rr_reg_write_lane #(.PW(PW), .LANE(i)) u_lane (
      .take_gnt    (take_gnt),
      .release_own (release_own),
      .wr_en       (wr_en),
      .sel_idx     (sel_idx),
      .owner       (owner_q),
      .gnt_q_i     (gnt_q[i]),
      .gnt_d_o     (gnt_d[i]),
      .ack_d_o     (ack_d[i])
    );
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.q     = q_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWNED);
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Scoreboard bench for rr_reg_write_arbiter. The stimulus pushes the grants
// and acks it expects. A monitor on the falling edge pops these entries and
// compares them with what the arbiter presents.
module tb_rr_reg_write_arbiter;
  logic clk;
  logic reset;

  rr_reg_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus();

  rr_reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
  } ack_exp_t;

  ack_exp_t   ack_exp[$];
  logic [3:0] gnt_exp[$];
  ack_exp_t   ea;
  logic [3:0] eg;
  logic [3:0] prev_gnt;
  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic [3:0] a, input logic [7:0] v);
    ack_exp_t e;
    e.ack = a;
    e.q   = v;
    ack_exp.push_back(e);
  endtask

  // Monitor: each ack pulse and each new grant must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.ack != 4'b0) begin
      checks++;
      if (ack_exp.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual=%b q=%h expected=none", bus.ack, bus.q);
      end else begin
        ea = ack_exp.pop_front();
        if (bus.ack !== ea.ack || bus.q !== ea.q) begin
          failures++;
          $display("FAIL ack_q actual=%b/%h expected=%b/%h", bus.ack, bus.q, ea.ack, ea.q);
        end
      end
    end
    if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
      checks++;
      if (gnt_exp.size() == 0) begin
        failures++;
        $display("FAIL unexpected_gnt actual=%b expected=none", bus.gnt);
      end else begin
        eg = gnt_exp.pop_front();
        if (bus.gnt !== eg) begin
          failures++;
          $display("FAIL gnt_order actual=%b expected=%b", bus.gnt, eg);
        end
      end
    end
    prev_gnt <= bus.gnt;
  end

  initial begin
    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus.lock  = 4'b0000;
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held for two edges while every lane requests.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_q",    32'(bus.q),    32'h0);
      chk("rst_gnt",  32'(bus.gnt),  32'h0);
      chk("rst_ack",  32'(bus.ack),  32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
    end

    // Fairness: requests held, no lock. Grants go 0,1,2,3,0 on alternate edges.
    gnt_exp.push_back(4'b0001); push_ack(4'b0001, 8'h11);
    gnt_exp.push_back(4'b0010); push_ack(4'b0010, 8'h22);
    gnt_exp.push_back(4'b0100); push_ack(4'b0100, 8'h33);
    gnt_exp.push_back(4'b1000); push_ack(4'b1000, 8'h44);
    gnt_exp.push_back(4'b0001); push_ack(4'b0001, 8'h11);
    reset = 1'b0;
    tick();
    chk("first_gnt_req0", 32'(bus.gnt), 32'h1);
    chk("first_owner",    32'(bus.owner), 32'h0);
    for (int i = 0; i < 9; i++) tick();
    chk("fair_last_ack", 32'(bus.ack), 32'h1);
    bus.req = 4'b0000;

    // Single unlocked write from requester 2.
    tick();
    bus.req   = 4'b0100;
    bus.wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    gnt_exp.push_back(4'b0100); push_ack(4'b0100, 8'hA5);
    tick();
    chk("single_gnt",   32'(bus.gnt),   32'h4);
    chk("single_busy",  32'(bus.busy),  32'h1);
    chk("single_owner", 32'(bus.owner), 32'h2);
    chk("single_q_hold", 32'(bus.q),    32'h11);
    tick();
    chk("single_q",     32'(bus.q),    32'hA5);
    chk("single_ack",   32'(bus.ack),  32'h4);
    chk("single_gnt0",  32'(bus.gnt),  32'h0);
    chk("single_idle",  32'(bus.busy), 32'h0);
    bus.req = 4'b0000;
    tick();
    chk("ack_one_cycle", 32'(bus.ack), 32'h0);

    // Withdraw: requester 0 is granted, then drops req before its write edge.
    bus.req = 4'b0001;
    gnt_exp.push_back(4'b0001);
    tick();
    chk("wd_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    tick();
    chk("wd_busy", 32'(bus.busy), 32'h0);
    chk("wd_gnt0", 32'(bus.gnt),  32'h0);
    chk("wd_q",    32'(bus.q),    32'hA5);
    chk("wd_ack",  32'(bus.ack),  32'h0);

    // Lock bound: lane 1 writes four times under lock and is then released.
    // Lane 3 is waiting and must be granted next, not lane 1.
    bus.req   = 4'b1010;
    bus.lock  = 4'b0010;
    bus.wdata = {8'h77, 8'h33, 8'h01, 8'h11};
    gnt_exp.push_back(4'b0010);
    tick();
    chk("lock_gnt1", 32'(bus.gnt), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      bus.wdata[1] = 8'(k);
      push_ack(4'b0010, 8'(k));
      if (k == 4) begin
        gnt_exp.push_back(4'b1000);
        push_ack(4'b1000, 8'h77);
      end
      tick();
      chk("lock_q", 32'(bus.q), 32'(k));
      if (k < 4) chk("lock_hold_gnt", 32'(bus.gnt), 32'h2);
    end
    chk("lock_release_gnt", 32'(bus.gnt),  32'h0);
    chk("lock_release_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("lock_next_gnt3", 32'(bus.gnt), 32'h8);
    tick();
    chk("wrap_q", 32'(bus.q), 32'h77);
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    tick();

    // Reset during a locked burst by lane 2. After reset, arbitration restarts from lane 0.
    bus.req   = 4'b0100;
    bus.lock  = 4'b0100;
    bus.wdata = {8'h77, 8'h3C, 8'h01, 8'h5A};
    gnt_exp.push_back(4'b0100);
    tick();
    chk("mid_gnt2", 32'(bus.gnt), 32'h4);
    push_ack(4'b0100, 8'h3C);
    tick();
    chk("mid_q", 32'(bus.q), 32'h3C);
    reset = 1'b1;
    tick();
    chk("mid_rst_q",    32'(bus.q),    32'h0);
    chk("mid_rst_ack",  32'(bus.ack),  32'h0);
    chk("mid_rst_gnt",  32'(bus.gnt),  32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    reset    = 1'b0;
    bus.req  = 4'b0101;
    bus.lock = 4'b0000;
    gnt_exp.push_back(4'b0001);
    push_ack(4'b0001, 8'h5A);
    tick();
    chk("post_rst_gnt0", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0000;
    tick();
    tick();

    chk("ack_queue_drained", 32'(ack_exp.size()), 32'h0);
    chk("gnt_queue_drained", 32'(gnt_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
